// File: rtl/vga_arb_pkg.sv
// Shared types and default sizes for the VGA draw-port arbiter.
// The FSM encoding is fixed so that state_dbg values stay stable for probes.
package vga_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAW  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_X_W     = 8;
    localparam int DEF_Y_W     = 7;
    localparam int DEF_C_W     = 9;
    localparam int DEF_TIMEOUT = 20000;

endpackage

// File: rtl/vga_draw_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or above pointer,
// wrapping from NUM_REQ-1 back to 0. Result is one-hot with a valid flag.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit holds pointer+i before folding it back into range
            sum = {1'b0, pointer} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single vga_adapter pixel port. One engine at a
// time gets a start pulse, then its pixel stream is forwarded until done.
module vga_draw_arbiter
    import vga_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int C_W     = DEF_C_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*X_W-1:0] x_in,
    input  logic [NUM_REQ*Y_W-1:0] y_in,
    input  logic [NUM_REQ*C_W-1:0] c_in,
    input  logic [NUM_REQ-1:0]     plot_in,
    input  logic [NUM_REQ-1:0]     done_in,
    output logic [NUM_REQ-1:0]     start_out,
    output logic [NUM_REQ-1:0]     grant,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [1:0]             state_dbg
);

    // Handshake: req is a level request sampled only in IDLE. A grant is
    // held from START until done_in of the owner (or timeout), then released
    // through a one-cycle GAP; start_out pulses exactly once per grant.

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   g_idx;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               to_nxt;
    logic               g_done;
    logic               cnt_last;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req     (req),
        .pointer (ptr),
        .pick    (pick),
        .valid   (pick_valid)
    );

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) g_idx = PTR_W'(i);
        end
    end

    assign g_done    = done_in[g_idx];
    assign cnt_last  = (cnt == CNT_W'(TIMEOUT - 1));
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            ptr         <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            timeout_err <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        to_nxt    = timeout_err;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_nxt = pick;
                    state_nxt = START;
                end
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = DRAW;
            end
            DRAW: begin
                cnt_nxt = cnt + CNT_W'(1);
                // Done wins over a coincident timeout
                if (g_done || cnt_last) begin
                    state_nxt = GAP;
                    grant_nxt = '0;
                    ptr_nxt   = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
                    if (!g_done) to_nxt = 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        start_out = '0;
        x         = '0;
        y         = '0;
        colour    = '0;
        plot      = 1'b0;
        busy      = (state == START) || (state == DRAW);
        if (state == START) start_out = grant;
        if (state == DRAW) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    x      = x_in[i*X_W +: X_W];
                    y      = y_in[i*Y_W +: Y_W];
                    colour = c_in[i*C_W +: C_W];
                    plot   = plot_in[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: a cycle table for one full grant
// plus hand-written fairness, timeout, async-reset and idle sequences.
module tb_vga_draw_arbiter;
    import vga_arb_pkg::*;

    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 9;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req, plot_in, done_in;
    logic [N*XW-1:0]   x_in;
    logic [N*YW-1:0]   y_in;
    logic [N*CW-1:0]   c_in;
    logic [N-1:0]      start_out, grant;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [CW-1:0]     colour;
    logic              plot, busy, timeout_err;
    logic [1:0]        state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] plot_in;
        logic [N-1:0] done_in;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_start;
        logic         exp_busy;
        logic         exp_plot;
        int           exp_eng;
    } vec_t;

    vec_t vecs[17];

    vga_draw_arbiter #(
        .NUM_REQ (N),
        .X_W     (XW),
        .Y_W     (YW),
        .C_W     (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .x_in        (x_in),
        .y_in        (y_in),
        .c_in        (c_in),
        .plot_in     (plot_in),
        .done_in     (done_in),
        .start_out   (start_out),
        .grant       (grant),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [XW-1:0] ex(int i);
        return XW'(16 * i + 3);
    endfunction
    function automatic logic [YW-1:0] ey(int i);
        return YW'(10 * i + 5);
    endfunction
    function automatic logic [CW-1:0] ec(int i);
        return CW'(50 * i + 7);
    endfunction

    function automatic vec_t mk(logic [N-1:0] r, logic [N-1:0] p, logic [N-1:0] d,
                                logic [N-1:0] g, logic [N-1:0] s, logic b, logic pl, int e);
        vec_t v;
        v.req = r; v.plot_in = p; v.done_in = d;
        v.exp_grant = g; v.exp_start = s; v.exp_busy = b; v.exp_plot = pl; v.exp_eng = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        plot_in = '0;
        done_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int idx, output int cycles);
        logic found;
        found  = 1'b0;
        idx    = -1;
        cycles = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            cycles++;
            if (start_out != '0) begin
                found = 1'b1;
                for (int i = 0; i < N; i++) if (start_out[i]) idx = i;
            end
        end
        check("start_seen", 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, cyc;
        for (int i = 0; i < N; i++) begin
            x_in[i*XW +: XW] = ex(i);
            y_in[i*YW +: YW] = ey(i);
            c_in[i*CW +: CW] = ec(i);
        end
        reset = 1'b0; req = '0; plot_in = '0; done_in = '0;

        // Reset state, checked asynchronously before any clock edge
        #2 reset = 1'b1;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_start", 32'(start_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_pix", {7'd0, x, y, colour}, 32'd0);
        check("rst_to_err", 32'(timeout_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // Single grant to engine 1, then a pending 0/2 request resolved by the pointer
        vecs[0]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, -1);
        vecs[1]  = mk(4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 1, 0, -1);
        vecs[2]  = mk(4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, 1,  1);
        vecs[3]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1, 0,  1);
        vecs[4]  = mk(4'b0000, 4'b1101, 4'b1000, 4'b0010, 4'b0000, 1, 0,  1);
        vecs[5]  = mk(4'b0101, 4'b0010, 4'b0101, 4'b0010, 4'b0000, 1, 1,  1);
        vecs[6]  = mk(4'b0101, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, 1,  1);
        vecs[7]  = mk(4'b0101, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, 1,  1);
        vecs[8]  = mk(4'b0101, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, 1,  1);
        vecs[9]  = mk(4'b0101, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, 1,  1);
        vecs[10] = mk(4'b0101, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1, 1,  1);
        vecs[11] = mk(4'b0101, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, -1);
        vecs[12] = mk(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, -1);
        vecs[13] = mk(4'b0101, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1, 0, -1);
        vecs[14] = mk(4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1, 1,  2);
        vecs[15] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, -1);
        vecs[16] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, -1);

        do_reset();
        for (int v = 0; v < 17; v++) begin
            req     = vecs[v].req;
            plot_in = vecs[v].plot_in;
            done_in = vecs[v].done_in;
            @(negedge clk);
            check($sformatf("tbl%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
            check($sformatf("tbl%0d_start", v), 32'(start_out), 32'(vecs[v].exp_start));
            check($sformatf("tbl%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            check($sformatf("tbl%0d_plot", v), 32'(plot), 32'(vecs[v].exp_plot));
            check($sformatf("tbl%0d_x", v), 32'(x),
                  (vecs[v].exp_eng < 0) ? 32'd0 : 32'(ex(vecs[v].exp_eng)));
            check($sformatf("tbl%0d_y", v), 32'(y),
                  (vecs[v].exp_eng < 0) ? 32'd0 : 32'(ey(vecs[v].exp_eng)));
            check($sformatf("tbl%0d_colour", v), 32'(colour),
                  (vecs[v].exp_eng < 0) ? 32'd0 : 32'(ec(vecs[v].exp_eng)));
            @(posedge clk);
            #1;
        end

        // Fairness: all four request continuously, each finishes 5 cycles after start
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start(idx, cyc);
            check("fair_order", 32'(idx), 32'(k % 4));
            check("fair_spacing", 32'(cyc), (k == 0) ? 32'd2 : 32'd3);
            check("fair_grant", 32'(grant), 32'(1 << (k % 4)));
            repeat (5) @(posedge clk);
            #1 done_in = 4'(1 << (k % 4));
            @(posedge clk);
            #1 done_in = '0;
        end
        req = '0;

        // Timeout: engine 2 never finishes
        do_reset();
        req = 4'b0100;
        wait_start(idx, cyc);
        req = '0;
        for (int d = 1; d <= TO; d++) @(negedge clk);
        check("to_last_draw_busy", 32'(busy), 32'd1);
        check("to_err_before", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("to_gap_state", 32'(state_dbg), 32'(GAP));
        check("to_gap_grant", 32'(grant), 32'd0);
        check("to_err_set", 32'(timeout_err), 32'd1);
        req = 4'b0001;
        wait_start(idx, cyc);
        check("to_next_owner", 32'(idx), 32'd0);
        req = '0;
        @(posedge clk);
        #1 done_in = 4'b0001;
        @(negedge clk);
        check("to_err_sticky_draw", 32'(timeout_err), 32'd1);
        @(posedge clk);
        #1 done_in = '0;
        @(negedge clk);
        check("to_err_sticky_gap", 32'(timeout_err), 32'd1);
        check("to_release", 32'(grant), 32'd0);

        // Done coinciding with the last DRAW cycle, plus a spurious done from engine 3
        do_reset();
        req = 4'b0001;
        wait_start(idx, cyc);
        req = '0;
        for (int d = 1; d <= TO; d++) begin
            @(posedge clk);
            #1 done_in = (d == 3) ? 4'b1000 : (d == TO) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (d == 3) begin
                check("spur_grant_held", 32'(grant), 32'b0001);
                check("spur_busy", 32'(busy), 32'd1);
            end
        end
        @(posedge clk);
        #1 done_in = '0;
        @(negedge clk);
        check("coinc_state", 32'(state_dbg), 32'(GAP));
        check("coinc_no_err", 32'(timeout_err), 32'd0);

        // Async reset between clock edges while drawing
        do_reset();
        req = 4'b0010;
        wait_start(idx, cyc);
        req = '0;
        plot_in = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        check("ar_plot_before", 32'(plot), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("ar_plot", 32'(plot), 32'd0);
        check("ar_grant", 32'(grant), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_pix", {7'd0, x, y, colour}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        plot_in = '0;
        req     = 4'b1000;
        @(negedge clk);
        check("ar_regrant", 32'(grant), 32'b1000);
        check("ar_restart", 32'(start_out), 32'b1000);
        req = '0;
        @(posedge clk);
        #1 done_in = 4'b1000;
        @(posedge clk);
        #1 done_in = '0;

        // Idle: no requests, random engine noise must never reach the adapter
        do_reset();
        for (int c = 0; c < 100; c++) begin
            plot_in = 4'($urandom_range(0, 15));
            done_in = 4'($urandom_range(0, 15));
            @(negedge clk);
            check("idle_pix", {7'd0, plot, x, y, colour}, 32'd0);
            check("idle_ctl", {23'd0, busy, start_out, grant}, 32'd0);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
